// File: rtl/regfile_mp_pkg.sv
// Shared CPU package for the multi-port register file.
// Holds the default datapath geometry, the stack-pointer reset value and the
// state encoding of the register dump controller.
package regfile_mp_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned NREGS_DEF   = 32;
  localparam int unsigned SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

  typedef enum logic [0:0] {
    StIdle,
    StDump
  } dump_state_e;

endpackage

// File: rtl/regfile_mp_dump_ctrl.sv
// Sequencer for the register dump stream.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   dump_start  - request a dump (ignored while a dump is running)
//   dump_ready  - consumer accepts the current beat
//   dump_valid  - a beat is being presented
//   dump_idx    - register index of the current beat
//   dump_done   - one-cycle pulse after the final beat is accepted
module regfile_dump_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic          dump_done
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    dump_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StDump;
          idx_d   = '0;
        end
      end
      StDump: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dump_idx  = idx_q;
  assign dump_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and dump stream.
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   rs_addr / rs_dout      - NREAD packed asynchronous read ports
//   rs_busy                - per read port: addressed register has a pending write
//   rd, rd_din, write_enable - single write port
//   claim_en, claim_rd     - mark a register pending (long-latency producer issued)
//   dump_*                 - sequential valid/ready dump of all registers
// x0 is hardwired to zero; register SP_IDX resets to SP_INIT.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter bit          BYPASS  = 1'b1,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_dout,
  output logic [NREAD-1:0]      rs_busy,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       rd_din,
  input  logic                  write_enable,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_rd,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [AW-1:0]         dump_idx,
  output logic [XLEN-1:0]       dump_data,
  output logic                  dump_done
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_live;

  assign wr_live = write_enable && (rd != '0);

  // Clear on write first, then set on claim, so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    if (write_enable) busy_d[rd] = 1'b0;
    if (claim_en && (claim_rd != '0)) busy_d[claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_live) rf_q[rd] <= rd_din;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rs_addr[k*AW +: AW];
    // Forward the in-flight write; that also resolves the pending state.
    assign hit  = BYPASS && wr_live && (rd == addr);
    assign rs_dout[k*XLEN +: XLEN] = hit ? rd_din :
                                     (addr == '0) ? {XLEN{1'b0}} : rf_q[addr];
    assign rs_busy[k] = hit ? 1'b0 : busy_q[addr];
  end

  regfile_dump_ctrl #(
    .NREGS(NREGS)
  ) u_dump_ctrl (
    .clk       (clk),
    .reset     (reset),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_done (dump_done)
  );

  // Dump reads stored state only; an unaccepted beat tracks later writes.
  assign dump_data = (dump_idx == '0) ? {XLEN{1'b0}} : rf_q[dump_idx];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of two, 2..64); AW = clog2(NREGS).
REQ-003 Parameter NREAD, default 2, number of asynchronous read ports (1..4).
REQ-004 Parameter SP_IDX, default 2, index of the stack-pointer register.
REQ-005 Parameter SP_INIT, default 32'h2ffc, reset value of the stack-pointer register.
REQ-006 Parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-007 Ports: one clock and one reset; reset is synchronous and active-high.
REQ-008 clk  in  1  clock; all state updates on the rising edge.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 rs_addr  in  NREAD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-011 rs_dout  out  NREAD*XLEN  packed read data; port k occupies bits [k*XLEN +: XLEN].
REQ-012 rs_busy  out  NREAD  port k reads a register with a pending write.
REQ-013 rd  in  AW  write address.
REQ-014 rd_din  in  XLEN  write data.
REQ-015 write_enable  in  1  commits rd_din to rd.
REQ-016 claim_en  in  1  marks claim_rd as pending (issue of a long-latency producer).
REQ-017 claim_rd  in  AW  register to mark pending.
REQ-018 dump_start  in  1  requests a sequential dump of all registers.
REQ-019 dump_valid  out  1  dump beat valid.
REQ-020 dump_ready  in  1  consumer accepts the dump beat.
REQ-021 dump_idx  out  AW  index of the current dump beat.
REQ-022 dump_data  out  XLEN  value of register dump_idx.
REQ-023 dump_done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-024 Register 0 SHALL always read 0; writes to it and claims on it SHALL be ignored.
REQ-025 Writes SHALL take effect at the rising edge when write_enable=1 and rd!=0.
REQ-026 rs_dout port k SHALL be rf[rs_addr k], combinationally.
REQ-027 With BYPASS=1, write_enable=1, rd=rs_addr k and rd!=0, port k SHALL output rd_din in the same cycle.
REQ-028 With BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-029 busy[claim_rd] SHALL set at the edge when claim_en=1 and claim_rd!=0.
REQ-030 busy[rd] SHALL clear at the edge when write_enable=1.
REQ-031 If a claim and a write target the same register in the same cycle, the set SHALL win.
REQ-032 rs_busy k SHALL equal busy[rs_addr k], except that it is 0 when the bypass of REQ-027 applies.
REQ-033 The dump FSM SHALL have two states, IDLE and DUMP.
REQ-034 In IDLE, dump_start=1 SHALL move the FSM to DUMP with dump_idx=0.
REQ-035 In DUMP, dump_valid SHALL be 1 and dump_data SHALL equal the stored rf[dump_idx], without bypass.
REQ-036 In DUMP, dump_idx SHALL advance by 1 on each cycle with dump_ready=1.
REQ-037 When dump_ready=1 at dump_idx=NREGS-1, the FSM SHALL return to IDLE and assert dump_done for exactly the next cycle.
REQ-038 dump_start SHALL be ignored while in DUMP.
REQ-039 Writes SHALL continue normally during a dump; a beat not yet accepted SHALL reflect the new value.

Reset
REQ-040 On reset, all registers SHALL be cleared to 0, except register SP_IDX, which SHALL be loaded with SP_INIT.
REQ-041 On reset, all busy bits SHALL clear and the FSM SHALL enter IDLE.
REQ-042 After reset, dump_valid=0, dump_done=0 and dump_idx=0.
REQ-043 Reset SHALL override write_enable and claim_en in the same cycle.
REQ-044 Reset during DUMP SHALL abort the dump without asserting dump_done.

Structure
REQ-045 The shared CPU package SHALL hold the default XLEN, NREGS, SP_IDX and SP_INIT values and the dump FSM state enum.
REQ-046 The dump FSM SHALL be a sub-module, regfile_dump_ctrl, that takes NREGS and outputs the index, valid and done signals.

Verification
REQ-047 Reset, then read ports 0 and 1 at x2 and x5 -> outputs 0x2ffc and 0.
REQ-048 write_enable=1, rd=5, rd_din=0xdeadbeef, rs_addr0=5 in the same cycle -> rs_dout0=0xdeadbeef in that cycle (BYPASS=1); next cycle it still reads 0xdeadbeef.
REQ-049 Write rd=0 with 0x1234 -> x0 reads 0.
REQ-050 claim_en on x7, then read x7 -> rs_busy=1; write x7=9 -> the write cycle shows busy=0 via bypass; claim and write x7 in the same cycle -> busy stays 1.
REQ-051 Dump with dump_ready toggling every other cycle -> 32 beats with idx 0..31 and correct data; dump_done pulses once; a dump_start during DUMP is ignored.
REQ-052 Reset at dump_idx=10 -> dump_valid=0 on the next cycle, no dump_done, x2=0x2ffc.
